mac_array_ctrl: RTL and testbench

Sequencer for the systolic MAC array built from mac_row/mac_tile instances. It drives the shared 2-bit instruction that enters the west edge of each row (bit0 = kernel load, bit1 = execute) and pops the L0 input buffer in lock-step with it. It then counts psum-valid pulses from the bottom row to detect completion. It runs one kernel-load, flush, execute and drain pass per start command and reports busy/done/err to the top-level core.

---
 rtl/mac_pkg.sv | 29 ++
 rtl/mac_ctrl_cnt.sv | 31 +++
 rtl/mac_array_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mac_array_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the systolic MAC array: instruction codes, sequencer
// states and default array dimensions.
package mac_pkg;

  localparam int unsigned MAC_ROWS = 8;
  localparam int unsigned MAC_COLS = 8;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } ctrl_state_e;

  // Largest of three sizes, used to dimension shared counters.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mac_ctrl_cnt.sv
// Loadable up-counter with enable, synchronous clear and a terminal-value compare.
module mac_ctrl_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term_c
);

  // Clear has priority over load, load over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_term_c = (cnt == term);

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for the systolic MAC array: kernel load, flush, execute and drain
// per start command, with completion counted from bottom-row psum-valid pulses.
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned row      = MAC_ROWS,
  parameter int unsigned col      = MAC_COLS,
  parameter int unsigned len_bw   = 8,
  parameter int unsigned drain_to = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [len_bw-1:0] n_vec,
  input  logic              act_mode_in,
  input  logic              l0_empty,
  output logic              l0_rd,
  output logic [1:0]        inst_w,
  output logic              act_mode,
  input  logic [col-1:0]    array_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_MAX = max3(col, row + col, 1 << len_bw);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned TW      = $clog2(drain_to + 1);
  localparam int unsigned VW      = len_bw + 1;

  ctrl_state_e       state, state_next;
  logic [len_bw-1:0] n_vec_q;
  logic [VW-1:0]     vcnt;

  logic          cnt_clr, cnt_en, cnt_at_term;
  logic [CW-1:0] cnt_term, cnt_q;
  logic          to_clr, to_en, to_at_term;
  logic [TW-1:0] to_q;

  logic [1:0] inst_w_d;
  logic       l0_rd_d;
  logic       accept;
  logic       err_set;
  logic       vld_tap;
  logic       unused_valid;

  // Only the last column of the bottom row marks a finished vector.
  assign vld_tap      = array_valid[col-1];
  assign unused_valid = ^array_valid;

  mac_ctrl_cnt #(.W(CW)) u_cnt (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .ld        (1'b0),
    .ld_val    ('0),
    .term      (cnt_term),
    .cnt       (cnt_q),
    .at_term_c (cnt_at_term)
  );

  mac_ctrl_cnt #(.W(TW)) u_drain_to (
    .clk       (clk),
    .rst_n     (reset),
    .clr       (to_clr),
    .en        (to_en),
    .ld        (1'b0),
    .ld_val    ('0),
    .term      (TW'(drain_to - 1)),
    .cnt       (to_q),
    .at_term_c (to_at_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the values the output registers take on the next edge.
  always_comb begin
    state_next = state;
    inst_w_d   = INST_IDLE;
    l0_rd_d    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cnt_term   = '0;
    to_clr     = 1'b0;
    to_en      = 1'b0;
    accept     = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          cnt_clr    = 1'b1;
          to_clr     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_term = CW'(col - 1);
        if (!l0_empty) begin
          inst_w_d = INST_LOAD;
          l0_rd_d  = 1'b1;
          if (cnt_at_term) begin
            cnt_clr    = 1'b1;
            state_next = FLUSH;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      FLUSH: begin
        cnt_term = CW'(row + col - 1);
        if (cnt_at_term) begin
          cnt_clr    = 1'b1;
          state_next = (n_vec_q == '0) ? DONE : EXEC;
        end else begin
          cnt_en = 1'b1;
        end
      end
      EXEC: begin
        cnt_term = CW'(n_vec_q) - CW'(1);
        if (!l0_empty) begin
          inst_w_d = INST_EXEC;
          l0_rd_d  = 1'b1;
          if (cnt_at_term) begin
            cnt_clr    = 1'b1;
            to_clr     = 1'b1;
            state_next = DRAIN;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Completion takes priority over a timeout in the same cycle.
        if (vcnt == {1'b0, n_vec_q}) begin
          state_next = DONE;
        end else if (to_at_term) begin
          err_set    = 1'b1;
          state_next = DONE;
        end else begin
          to_en = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_w   <= INST_IDLE;
      l0_rd    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      act_mode <= 1'b0;
      n_vec_q  <= '0;
    end else begin
      inst_w <= inst_w_d;
      l0_rd  <= l0_rd_d;
      busy   <= (state != IDLE);
      done   <= (state == DONE);
      if (accept) begin
        err      <= 1'b0;
        act_mode <= act_mode_in;
        n_vec_q  <= n_vec;
      end else if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  // Output-vector counter; saturates so a runaway array cannot wrap it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcnt <= '0;
    end else if (accept) begin
      vcnt <= '0;
    end else if ((state == EXEC || state == DRAIN) && vld_tap && (vcnt != '1)) begin
      vcnt <= vcnt + VW'(1);
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Randomized self-checking bench for mac_array_ctrl against a phase-level model
// of one pass (word counts per phase, pulse schedule, drain timeout).
module tb_mac_array_ctrl;
  import mac_pkg::*;

  localparam int unsigned ROW  = 8;
  localparam int unsigned COL  = 8;
  localparam int unsigned LBW  = 8;
  localparam int unsigned DTO  = 64;
  localparam int          MAXI = 512;

  logic           clk = 1'b0;
  logic           reset, start, act_mode_in, l0_empty;
  logic           l0_rd, act_mode, busy, done, err;
  logic [LBW-1:0] n_vec;
  logic [1:0]     inst_w;
  logic [COL-1:0] array_valid;

  mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(LBW), .drain_to(DTO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .n_vec       (n_vec),
    .act_mode_in (act_mode_in),
    .l0_empty    (l0_empty),
    .l0_rd       (l0_rd),
    .inst_w      (inst_w),
    .act_mode    (act_mode),
    .array_valid (array_valid),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    n;
    int    mode;
    int    npulse;
    bit    tie;
    bit    tog;
  } row_t;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  bit         drv_empty[$];
  bit         pulse_at[MAXI];
  int         exp_done, load_len;
  bit         exp_err;
  logic [1:0] obs_inst[MAXI];
  logic       obs_rd[MAXI], obs_done[MAXI], obs_busy[MAXI], obs_err[MAXI], obs_act[MAXI];

  // Expected per-cycle instruction stream; mode 0 no stalls, 1 random, 2 directed.
  task automatic build_pass(input int n, input int mode);
    int words, st;
    bit e;
    exp_q.delete();
    drv_empty.delete();
    words = 0; st = 0;
    while (words < COL) begin
      if (mode == 1) e = ($urandom_range(0, 99) < 30);
      else if (mode == 2) e = (words == 4 && st < 3);
      else e = 1'b0;
      if (e) st++; else words++;
      drv_empty.push_back(e);
      exp_q.push_back(e ? INST_IDLE : INST_LOAD);
    end
    load_len = exp_q.size();
    repeat (ROW + COL) begin
      drv_empty.push_back(1'($urandom));
      exp_q.push_back(INST_IDLE);
    end
    words = 0; st = 0;
    while (words < n) begin
      if (mode == 1) e = ($urandom_range(0, 99) < 30);
      else if (mode == 2) e = (words == 2 && st < 2);
      else e = 1'b0;
      if (e) st++; else words++;
      drv_empty.push_back(e);
      exp_q.push_back(e ? INST_IDLE : INST_EXEC);
    end
  endtask

  // Pulse schedule on array_valid[COL-1] and the resulting done cycle / err.
  task automatic place_pulses(input int n, input int npulse, input bit tie);
    int k, ex, c, cnt, pn;
    foreach (pulse_at[i]) pulse_at[i] = 1'b0;
    for (int i = 0; i < 4; i++) pulse_at[i] = 1'($urandom);
    k  = exp_q.size() - 1;
    ex = load_len + ROW + COL;
    if (tie) begin
      for (int j = 0; j < npulse; j++) pulse_at[k + DTO - npulse + j] = 1'b1;
    end else begin
      c = ex;
      for (int j = 0; j < npulse; j++) begin
        c += $urandom_range(0, 3);
        pulse_at[c] = 1'b1;
        c++;
      end
    end
    cnt = 0; pn = -1;
    for (int i = ex; i < MAXI; i++) begin
      if (pulse_at[i]) begin
        cnt++;
        if (cnt == n && pn < 0) pn = i;
      end
    end
    exp_err = 1'b0;
    if (n == 0) exp_done = exp_q.size() + 1;
    else if (pn >= 0 && pn <= k + DTO - 1) exp_done = ((pn > k) ? pn : k) + 3;
    else begin
      exp_done = k + DTO + 2;
      exp_err  = 1'b1;
    end
  endtask

  // Issues one start and records outputs for every cycle of the pass.
  task automatic run_pass(input int n, input bit am, input bit tog);
    @(negedge clk);
    n_vec = LBW'(n); act_mode_in = am; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i <= exp_done + 2; i++) begin
      @(negedge clk);
      obs_inst[i] = inst_w; obs_rd[i] = l0_rd; obs_done[i] = done;
      obs_busy[i] = busy; obs_err[i] = err; obs_act[i] = act_mode;
      start       = (tog && i < exp_done - 1) ? 1'($urandom) : 1'b0;
      act_mode_in = tog ? 1'($urandom) : am;
      n_vec       = tog ? LBW'($urandom) : n_vec;
      l0_empty    = (i < drv_empty.size()) ? drv_empty[i] : 1'($urandom);
      array_valid = COL'($urandom);
      array_valid[COL-1] = pulse_at[i];
    end
    start = 1'b0; array_valid = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; n_vec = '0; act_mode_in = 1'b1;
    l0_empty = 1'b1; array_valid = '1;
    #12;
    n_cmp++;
    if ({inst_w, l0_rd, busy, done, err, act_mode} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state: inst=%b rd=%b busy=%b done=%b err=%b act=%b, required all 0",
               inst_w, l0_rd, busy, done, err, act_mode);
    end
    @(negedge clk); reset = 1'b1; array_valid = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({inst_w, l0_rd, busy, done} !== 5'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: inst=%b rd=%b busy=%b done=%b, required all 0",
               inst_w, l0_rd, busy, done);
    end
  endtask

  task automatic test_passes;
    row_t tbl[$];
    row_t r;
    bit   am;
    tbl.push_back('{"basic",        4, 0, 4, 1'b0, 1'b0});
    tbl.push_back('{"stall",        4, 2, 4, 1'b0, 1'b0});
    tbl.push_back('{"nvec0",        0, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{"timeout",      4, 0, 3, 1'b0, 1'b0});
    tbl.push_back('{"timeout_tie",  4, 0, 4, 1'b1, 1'b0});
    tbl.push_back('{"start_ignore", 5, 1, 5, 1'b0, 1'b1});
    for (int j = 0; j < 8; j++) begin
      r.name = "random"; r.n = $urandom_range(1, 12); r.mode = 1;
      r.npulse = r.n + $urandom_range(0, 1); r.tie = 1'b0; r.tog = 1'($urandom);
      tbl.push_back(r);
    end
    foreach (tbl[t]) begin
      am = 1'($urandom);
      build_pass(tbl[t].n, tbl[t].mode);
      place_pulses(tbl[t].n, tbl[t].npulse, tbl[t].tie);
      run_pass(tbl[t].n, am, tbl[t].tog);
      for (int i = 0; i <= exp_done + 2; i++) begin
        logic [1:0] ei;
        logic       eb;
        ei = (i >= 1 && i - 1 < exp_q.size()) ? exp_q[i-1] : INST_IDLE;
        eb = (i >= 1 && i <= exp_done);
        n_cmp++;
        if (obs_inst[i] !== ei || obs_rd[i] !== (ei != INST_IDLE) ||
            obs_done[i] !== (i == exp_done) || obs_busy[i] !== eb || obs_act[i] !== am) begin
          n_err++;
          $display("FAIL %s cyc %0d: inst=%b rd=%b done=%b busy=%b act=%b, required inst=%b rd=%b done=%b busy=%b act=%b",
                   tbl[t].name, i, obs_inst[i], obs_rd[i], obs_done[i], obs_busy[i], obs_act[i],
                   ei, ei != INST_IDLE, i == exp_done, eb, am);
        end
      end
      n_cmp++;
      if (obs_err[exp_done] !== exp_err || obs_err[exp_done+2] !== exp_err) begin
        n_err++;
        $display("FAIL %s err: got %b/%b, required %b", tbl[t].name,
                 obs_err[exp_done], obs_err[exp_done+2], exp_err);
      end
    end
  endtask

  task automatic test_err_sticky;
    build_pass(4, 0); place_pulses(4, 3, 1'b0); run_pass(4, 1'b0, 1'b0);
    n_cmp++;
    if (obs_err[exp_done] !== 1'b1) begin
      n_err++;
      $display("FAIL err_set: got %b, required 1", obs_err[exp_done]);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    build_pass(2, 0); place_pulses(2, 2, 1'b0); run_pass(2, 1'b1, 1'b0);
    n_cmp++;
    if (obs_err[0] !== 1'b0 || obs_err[exp_done] !== 1'b0 || obs_done[exp_done] !== 1'b1) begin
      n_err++;
      $display("FAIL err_clear: err0=%b err_end=%b done=%b, required 0 0 1",
               obs_err[0], obs_err[exp_done], obs_done[exp_done]);
    end
  endtask

  task automatic test_reset_mid_exec;
    int nl, nx;
    @(negedge clk);
    n_vec = LBW'(20); act_mode_in = 1'b1; start = 1'b1; l0_empty = 1'b0; array_valid = '0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (28) @(posedge clk);
    #2;
    n_cmp++;
    if (inst_w !== INST_EXEC || busy !== 1'b1) begin
      n_err++;
      $display("FAIL exec_before_reset: inst=%b busy=%b, required 10 1", inst_w, busy);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({inst_w, l0_rd, busy, done, err, act_mode} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_mid_exec: inst=%b rd=%b busy=%b done=%b err=%b act=%b, required all 0",
               inst_w, l0_rd, busy, done, err, act_mode);
    end
    @(negedge clk); reset = 1'b1;
    build_pass(3, 0); place_pulses(3, 3, 1'b0); run_pass(3, 1'b0, 1'b0);
    nl = 0; nx = 0;
    for (int i = 0; i <= exp_done + 2; i++) begin
      if (obs_inst[i] === INST_LOAD) nl++;
      if (obs_inst[i] === INST_EXEC) nx++;
    end
    n_cmp++;
    if (nl != COL || nx != 3 || obs_done[exp_done] !== 1'b1) begin
      n_err++;
      $display("FAIL pass_after_reset: loads=%0d execs=%0d done=%b, required %0d 3 1",
               nl, nx, obs_done[exp_done], COL);
    end
  endtask

  initial begin
    test_reset();
    test_passes();
    test_err_sticky();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
